// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC controller: sequencer states,
// default PC geometry and the word-alignment helper used on redirect targets.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    localparam int                  PC_WIDTH = 6;
    localparam logic [PC_WIDTH-1:0] RESET_PC = '0;

    // Redirect targets are forced onto a word boundary; the dropped bits feed misalign.
    function automatic logic [PC_WIDTH-1:0] align_word(input logic [PC_WIDTH-1:0] addr);
        return {addr[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC controller: picks the next PC from sequential, branch, jump,
// stall and halt requests and tells the IF stage when to squash its latch.
module fetch_sequencer #(
    parameter int                  PC_WIDTH     = fetch_ctrl_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = fetch_ctrl_pkg::RESET_PC,
    parameter int                  FLUSH_CYCLES = 1,
    parameter int                  CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic                 jump,
    input  logic [PC_WIDTH-1:0]  jump_target,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic [PC_WIDTH-1:0]  PC,
    output logic                 IF_Flush,
    output logic                 fetch_valid,
    output logic                 misalign,
    output logic [CNT_WIDTH-1:0] redirect_count
);

    import fetch_ctrl_pkg::*;

    // Flush cycles spent in FLUSH after the accepting cycle itself.
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [1:0]          flush_cnt_q, flush_cnt_d;
    logic                misalign_q, misalign_d;
    logic                redirect;
    logic                redirect_accept;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc_inc;

    assign redirect = branch_taken | jump;
    assign target   = branch_taken ? branch_target : jump_target;
    assign pc_inc   = pc_q + PC_WIDTH'(4);

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        flush_cnt_d     = flush_cnt_q;
        misalign_d      = misalign_q;
        redirect_accept = 1'b0;
        IF_Flush        = 1'b1;
        fetch_valid     = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    redirect_accept = 1'b1;
                    pc_d            = align_word(target);
                    misalign_d      = misalign_q | (target[1:0] != 2'b00);
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    IF_Flush = 1'b0;
                end else begin
                    pc_d        = pc_inc;
                    IF_Flush    = 1'b0;
                    fetch_valid = 1'b1;
                end
            end
            ST_FLUSH: begin
                // A fresh redirect restarts the bubble train; halt_req is not honoured here.
                if (redirect) begin
                    redirect_accept = 1'b1;
                    pc_d            = align_word(target);
                    misalign_d      = misalign_q | (target[1:0] != 2'b00);
                    flush_cnt_d     = FLUSH_LOAD;
                end else begin
                    if (!stall) begin
                        pc_d = pc_inc;
                    end
                    flush_cnt_d = flush_cnt_q - 2'd1;
                    if (flush_cnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (rst) begin
            IF_Flush    = 1'b1;
            fetch_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            flush_cnt_q <= 2'd0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_cnt_q <= flush_cnt_d;
            misalign_q  <= misalign_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_redirect_cnt (
        .clk     (clk),
        .clr_i   (rst),
        .en_i    (redirect_accept),
        .count_o (redirect_count)
    );

    assign PC       = pc_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one default instance and one with
// FLUSH_CYCLES=3 / CNT_WIDTH=2, sharing stimulus; each step checks one of them.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       branch_taken;
    logic [5:0] branch_target;
    logic       jump;
    logic [5:0] jump_target;
    logic       halt_req;
    logic       resume;

    logic [5:0] pc_a, pc_b;
    logic       fl_a, fl_b, fv_a, fv_b, mis_a, mis_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string tag;
        bit    sel;
        int    pc;
        int    mis;
        int    cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_sequencer u_a (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .halt_req       (halt_req),
        .resume         (resume),
        .PC             (pc_a),
        .IF_Flush       (fl_a),
        .fetch_valid    (fv_a),
        .misalign       (mis_a),
        .redirect_count (cnt_a)
    );

    fetch_sequencer #(
        .FLUSH_CYCLES (3),
        .CNT_WIDTH    (2)
    ) u_b (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .halt_req       (halt_req),
        .resume         (resume),
        .PC             (pc_b),
        .IF_Flush       (fl_b),
        .fetch_valid    (fv_b),
        .misalign       (mis_b),
        .redirect_count (cnt_b)
    );

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, what, obs, expv);
        end
    endtask

    // One clock of stimulus. e_fl/e_fv are this cycle's combinational outputs
    // (-1 = not checked); e_pc/e_mis/e_cnt are the registered values after the edge.
    task automatic cyc(input string tag, input bit sel, input bit r, input bit br, input logic [5:0] bt,
                       input bit j, input logic [5:0] jt, input bit h, input bit res, input bit st,
                       input int e_fl, input int e_fv, input int e_pc, input int e_mis, input int e_cnt);
        exp_t e;
        @(negedge clk);
        rst           = r;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        halt_req      = h;
        resume        = res;
        stall         = st;
        #1;
        if (e_fl >= 0) chk(tag, "IF_Flush", sel ? fl_b : fl_a, e_fl);
        if (e_fv >= 0) chk(tag, "fetch_valid", sel ? fv_b : fv_a, e_fv);
        e.tag = tag; e.sel = sel; e.pc = e_pc; e.mis = e_mis; e.cnt = e_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, "PC", e.sel ? 32'(pc_b) : 32'(pc_a), e.pc);
        chk(e.tag, "misalign", e.sel ? 32'(mis_b) : 32'(mis_a), e.mis);
        chk(e.tag, "redirect_count", e.sel ? 32'(cnt_b) : 32'(cnt_a), e.cnt);
        $display("step %-12s pc_a=%02h pc_b=%02h fl=%0b/%0b fv=%0b/%0b cnt=%0d/%0d", tag, pc_a, pc_b, fl_a, fl_b, fv_a, fv_b, cnt_a, cnt_b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0; halt_req = 1'b0; resume = 1'b0;

        // ---- default instance: FLUSH_CYCLES=1, CNT_WIDTH=8 ----
        //  tag             sel r br bt     j  jt     h  re st  fl  fv  pc     mis cnt
        cyc("rst0",         0, 1, 0, 6'h00, 0, 6'h00, 0, 0, 0,  1,  0, 'h00, 0, 0);
        cyc("rst1",         0, 1, 0, 6'h00, 0, 6'h00, 0, 0, 0,  1,  0, 'h00, 0, 0);
        cyc("rst2",         0, 1, 0, 6'h00, 0, 6'h00, 0, 0, 0,  1,  0, 'h00, 0, 0);
        cyc("boot",         0, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  1,  0, 'h00, 0, 0);
        cyc("run0",         0, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  0,  1, 'h04, 0, 0);
        cyc("run4",         0, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  0,  1, 'h08, 0, 0);
        cyc("branch",       0, 0, 1, 6'h24, 0, 6'h00, 0, 0, 0,  1,  0, 'h24, 0, 1);
        cyc("post_br",      0, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  0,  1, 'h28, 0, 1);
        cyc("collide",      0, 0, 1, 6'h10, 1, 6'h30, 0, 0, 1,  1,  0, 'h10, 0, 2);
        cyc("stall",        0, 0, 0, 6'h00, 0, 6'h00, 0, 0, 1,  0,  0, 'h10, 0, 2);
        cyc("jmp_mis",      0, 0, 0, 6'h00, 1, 6'h13, 0, 0, 0,  1,  0, 'h10, 1, 3);
        cyc("seq",          0, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  0,  1, 'h14, 1, 3);
        cyc("halt_req",     0, 0, 0, 6'h00, 0, 6'h00, 1, 0, 0, -1,  0, 'h14, 1, 3);
        cyc("halt_br",      0, 0, 1, 6'h2C, 0, 6'h00, 0, 0, 0,  1,  0, 'h14, 1, 3);
        cyc("halt_jmp",     0, 0, 0, 6'h00, 1, 6'h30, 0, 0, 1,  1,  0, 'h14, 1, 3);
        cyc("resume",       0, 0, 0, 6'h00, 0, 6'h00, 0, 1, 0,  1,  0, 'h14, 1, 3);
        cyc("post_res",     0, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  0,  1, 'h18, 1, 3);
        cyc("res_in_run",   0, 0, 0, 6'h00, 0, 6'h00, 0, 1, 0,  0,  1, 'h1C, 1, 3);
        cyc("jmp_3c",       0, 0, 0, 6'h00, 1, 6'h3C, 0, 0, 0,  1,  0, 'h3C, 1, 4);
        cyc("wrap",         0, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  0,  1, 'h00, 1, 4);
        cyc("rst_clr",      0, 1, 0, 6'h00, 0, 6'h00, 0, 0, 0,  1,  0, 'h00, 0, 0);

        // ---- second instance: FLUSH_CYCLES=3, CNT_WIDTH=2 ----
        cyc("b_rst",        1, 1, 0, 6'h00, 0, 6'h00, 0, 0, 0,  1,  0, 'h00, 0, 0);
        cyc("b_boot",       1, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  1,  0, 'h00, 0, 0);
        cyc("b_run0",       1, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  0,  1, 'h04, 0, 0);
        cyc("b_run4",       1, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  0,  1, 'h08, 0, 0);
        cyc("b_branch",     1, 0, 1, 6'h24, 0, 6'h00, 0, 0, 0,  1,  0, 'h24, 0, 1);
        cyc("b_flush1",     1, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  1,  0, 'h28, 0, 1);
        cyc("b_flush2",     1, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  1,  0, 'h2C, 0, 1);
        cyc("b_run",        1, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  0,  1, 'h30, 0, 1);
        cyc("b_jmp0",       1, 0, 0, 6'h00, 1, 6'h00, 0, 0, 0,  1,  0, 'h00, 0, 2);
        cyc("b_fl_stall",   1, 0, 0, 6'h00, 0, 6'h00, 0, 0, 1,  1,  0, 'h00, 0, 2);
        cyc("b_fl_last",    1, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  1,  0, 'h04, 0, 2);
        cyc("b_run_again",  1, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  0,  1, 'h08, 0, 2);
        cyc("b_br20",       1, 0, 1, 6'h20, 0, 6'h00, 0, 0, 0,  1,  0, 'h20, 0, 3);
        cyc("b_fl_redir",   1, 0, 1, 6'h30, 0, 6'h00, 0, 0, 0,  1,  0, 'h30, 0, 3);
        cyc("b_fl_halt",    1, 0, 0, 6'h00, 0, 6'h00, 1, 0, 0,  1,  0, 'h34, 0, 3);
        cyc("b_fl_end",     1, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  1,  0, 'h38, 0, 3);
        cyc("b_run3c",      1, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  0,  1, 'h3C, 0, 3);
        cyc("b_sat",        1, 0, 0, 6'h00, 1, 6'h08, 0, 0, 0,  1,  0, 'h08, 0, 3);
        cyc("b_rst_flush",  1, 1, 0, 6'h00, 0, 6'h00, 0, 0, 0,  1,  0, 'h00, 0, 0);
        cyc("b_boot2",      1, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  1,  0, 'h00, 0, 0);
        cyc("b_run_post",   1, 0, 0, 6'h00, 0, 6'h00, 0, 0, 0,  0,  1, 'h04, 0, 0);

        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
